// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline register with an optional skid entry, flush squash
// and a saturating count of flushes that discarded live work.
module pipe_stage_hs #(
    parameter int DATA_W     = 175,
    parameter bit SKID       = 1'b1,
    parameter bit FLUSH_ZERO = 1'b1,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  main_q, main_d;
    logic [DATA_W-1:0]  skid_q, skid_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               accept;
    logic               consume;

    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (accept) state_d = ONE;
                ONE: begin
                    if (accept && !consume && SKID) state_d = TWO;
                    else if (!accept && consume) state_d = EMPTY;
                end
                TWO: if (consume) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Payload moves only on the listed transitions; flush may wipe it.
    always_comb begin
        main_d      = main_q;
        skid_d      = skid_q;
        flush_cnt_d = flush_cnt_q;
        if (flush) begin
            if (FLUSH_ZERO) begin
                main_d = '0;
                skid_d = '0;
            end
            if (state_q != EMPTY && flush_cnt_q != {CNT_W{1'b1}})
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else begin
            unique case (state_q)
                EMPTY: if (accept) main_d = in_data;
                ONE: begin
                    if (accept && consume) main_d = in_data;
                    else if (accept && SKID) skid_d = in_data;
                end
                TWO: if (consume) main_d = skid_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        out_valid = 1'b0;
        occupancy = 2'd0;
        unique case (state_q)
            EMPTY: ;
            ONE: begin
                out_valid = 1'b1;
                occupancy = 2'd1;
            end
            TWO: begin
                out_valid = 1'b1;
                occupancy = 2'd2;
            end
            default: ;
        endcase
    end

    generate
        if (SKID) begin : g_skid
            logic in_ready_q;
            logic in_ready_d;

            // Registered so upstream never sees a path from out_ready.
            assign in_ready_d = (state_d != TWO);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) in_ready_q <= 1'b1;
                else       in_ready_q <= in_ready_d;
            end

            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign in_ready = (state_q == EMPTY) | out_ready;
        end
    endgenerate

    assign out_data  = main_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: two configurations driven in lockstep and
// checked against a queue-level model plus directed literal expectations.
module tb_pipe_stage_hs;

    localparam int W = 175;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] in_data;

    logic         rdy0, ov0, rdy1, ov1;
    logic [W-1:0] od0, od1;
    logic [1:0]   occ0, occ1;
    logic [7:0]   fc0;
    logic [1:0]   fc1;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] va, vb, vc, vd;

    always #5 clk = ~clk;

    pipe_stage_hs #(.DATA_W(W), .SKID(1'b1), .FLUSH_ZERO(1'b1), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .occupancy(occ0), .flush_cnt(fc0)
    );

    pipe_stage_hs #(.DATA_W(W), .SKID(1'b0), .FLUSH_ZERO(1'b0), .CNT_W(2)) u_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .occupancy(occ1), .flush_cnt(fc1)
    );

    // Model: instance 0 = skid/zeroing/8-bit count, instance 1 = no skid/hold/2-bit
    logic [W-1:0] mq [2][2];
    int           mn [2];
    logic [W-1:0] msh [2];
    int           mc [2];

    function automatic bit sk(int i);
        return i == 0;
    endfunction

    function automatic bit fz(int i);
        return i == 0;
    endfunction

    function automatic int cmax(int i);
        return (i == 0) ? 255 : 3;
    endfunction

    function automatic bit m_rdy(int i);
        if (sk(i)) return mn[i] < 2;
        return (mn[i] == 0) || out_ready;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                mn[i]  = 0;
                mc[i]  = 0;
                msh[i] = '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit acc;
                bit con;
                acc = in_valid && m_rdy(i);
                con = (mn[i] > 0) && out_ready;
                if (flush) begin
                    if (mn[i] > 0 && mc[i] < cmax(i)) mc[i]++;
                    mn[i] = 0;
                    if (fz(i)) msh[i] = '0;
                end else begin
                    if (con) begin
                        mq[i][0] = mq[i][1];
                        mn[i]--;
                    end
                    if (acc) begin
                        mq[i][mn[i]] = in_data;
                        mn[i]++;
                    end
                    if (mn[i] > 0) msh[i] = mq[i][0];
                end
            end
        end
    end

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_inst(int i, logic r, logic v, logic [W-1:0] d,
                            logic [1:0] o, logic [7:0] c);
        chk($sformatf("in_ready%0d", i), W'(r), W'(m_rdy(i)));
        chk($sformatf("out_valid%0d", i), W'(v), W'(mn[i] > 0));
        chk($sformatf("out_data%0d", i), d, (mn[i] > 0) ? mq[i][0] : msh[i]);
        chk($sformatf("occupancy%0d", i), W'(o), W'(mn[i]));
        chk($sformatf("flush_cnt%0d", i), W'(c), W'(mc[i]));
    endtask

    always @(negedge clk) begin
        chk_inst(0, rdy0, ov0, od0, occ0, fc0);
        chk_inst(1, rdy1, ov1, od1, occ1, {6'd0, fc1});
    end

    task automatic set(logic v, logic [W-1:0] d, logic r, logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        va = {15'h7abc, {5{32'hdead_0001}}};
        vb = {15'h1234, {5{32'h5a5a_0002}}};
        vc = {15'h0f0f, {5{32'hc0de_0003}}};
        vd = {15'h4321, {5{32'hbeef_0004}}};
        reset = 1'b0;
        set(1'b0, '0, 1'b0, 1'b0);
        #1 reset = 1'b1;
        #21 reset = 1'b0;
        chk("rst_occ0", W'(occ0), W'(0));
        chk("rst_cnt0", W'(fc0), W'(0));
        chk("rst_rdy0", W'(rdy0), W'(1));

        // streaming 1..4 with a ready sink
        for (int k = 1; k <= 4; k++) begin
            set(1'b1, W'(k), 1'b1, 1'b0);
            tick();
        end
        chk("stream_out0", od0, W'(4));
        chk("stream_out1", od1, W'(4));
        chk("stream_occ0", W'(occ0), W'(1));
        chk("stream_rdy0", W'(rdy0), W'(1));
        set(1'b0, '0, 1'b1, 1'b0);
        tick();

        // backpressure: A then B with a stalled sink
        set(1'b1, va, 1'b0, 1'b0);
        tick();
        set(1'b1, vb, 1'b0, 1'b0);
        tick();
        chk("bp_occ0", W'(occ0), W'(2));
        chk("bp_rdy0", W'(rdy0), W'(0));
        chk("bp_out0", od0, va);
        chk("bp_occ1", W'(occ1), W'(1));
        chk("bp_rdy1", W'(rdy1), W'(0));
        chk("bp_out1", od1, va);
        set(1'b1, vb, 1'b1, 1'b0);
        tick();
        chk("bp_drain_out0", od0, vb);
        chk("bp_drain_out1", od1, vb);
        chk("bp_drain_rdy0", W'(rdy0), W'(1));
        set(1'b0, '0, 1'b1, 1'b0);
        tick();
        chk("bp_empty0", W'(occ0), W'(0));

        // flush at full occupancy while C is offered
        set(1'b1, va, 1'b0, 1'b0);
        tick();
        set(1'b1, vb, 1'b0, 1'b0);
        tick();
        set(1'b1, vc, 1'b0, 1'b1);
        tick();
        chk("fl_valid0", W'(ov0), W'(0));
        chk("fl_data0", od0, W'(0));
        chk("fl_occ0", W'(occ0), W'(0));
        chk("fl_cnt0", W'(fc0), W'(1));
        chk("fl_valid1", W'(ov1), W'(0));
        chk("fl_hold1", od1, va);
        chk("fl_cnt1", W'(fc1), W'(1));
        set(1'b0, '0, 1'b0, 1'b1);
        tick();
        chk("fl_empty_cnt0", W'(fc0), W'(1));
        chk("fl_empty_cnt1", W'(fc1), W'(1));

        // five counted flushes, some coinciding with a consume
        for (int k = 0; k < 5; k++) begin
            set(1'b1, W'(16 + k), 1'b0, 1'b0);
            tick();
            set(1'b0, '0, k[0], 1'b1);
            tick();
        end
        chk("sat_cnt1", W'(fc1), W'(3));
        chk("sat_cnt0", W'(fc0), W'(6));
        chk("sat_hold1", od1, W'(20));

        // async reset between edges while holding two entries
        set(1'b1, va, 1'b0, 1'b0);
        tick();
        set(1'b1, vb, 1'b0, 1'b0);
        tick();
        set(1'b0, '0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("ar_valid0", W'(ov0), W'(0));
        chk("ar_occ0", W'(occ0), W'(0));
        chk("ar_data0", od0, W'(0));
        chk("ar_valid1", W'(ov1), W'(0));
        chk("ar_data1", od1, W'(0));
        #4 reset = 1'b0;
        chk("ar_rdy0", W'(rdy0), W'(1));
        set(1'b1, vd, 1'b1, 1'b0);
        tick();
        chk("ar_d_out0", od0, vd);
        chk("ar_d_occ0", W'(occ0), W'(1));
        chk("ar_d_out1", od1, vd);
        set(1'b0, '0, 1'b1, 1'b0);
        tick();
        chk("ar_done_occ0", W'(occ0), W'(0));
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_hs.md
PIPE_STAGE_HS -- requirements
Module: pipe_stage_hs

Interface
REQ-001 Parameter DATA_W, default 175, payload width in bits (ID/EX bundle: 5x32 data + 3x5 register indices).
REQ-002 Parameter SKID, default 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
REQ-003 Parameter FLUSH_ZERO, default 1: 1 = payload registers cleared to 0 on flush; 0 = payload held, only valid cleared.
REQ-004 Parameter CNT_W, default 8, width of the flush counter.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high; clears all state.
REQ-007 flush  input  1  synchronous squash of all held entries (mispredict/nullify).
REQ-008 in_valid  input  1  upstream offers in_data.
REQ-009 in_ready  output  1  stage accepts in_data this cycle.
REQ-010 in_data  input  DATA_W  upstream payload.
REQ-011 out_valid  output  1  out_data holds a live entry.
REQ-012 out_ready  input  1  downstream consumes this cycle.
REQ-013 out_data  output  DATA_W  payload of the oldest entry (main register).
REQ-014 occupancy  output  2  number of live entries, 0..2.
REQ-015 flush_cnt  output  CNT_W  count of flushes that discarded at least one live entry; saturates.

Function
REQ-016 Accept = in_valid & in_ready; consume = out_valid & out_ready; both evaluated on the same edge.
REQ-017 States: EMPTY (occ 0), ONE (main valid), TWO (main and skid valid; only reachable when SKID=1).
REQ-018 EMPTY: accept -> ONE, main <= in_data; else stay.
REQ-019 ONE: accept & consume -> ONE, main <= in_data; accept only -> TWO, skid <= in_data (SKID=1); consume only -> EMPTY; neither -> hold.
REQ-020 TWO: in_ready = 0; consume -> ONE, main <= skid; else hold all.
REQ-021 SKID=1: in_ready = (state != TWO), a pure register output, no combinational path from out_ready.
REQ-022 SKID=0: in_ready = ~out_valid | out_ready; accept while full and not consumed is impossible.
REQ-023 out_valid = (state != EMPTY); out_data = main register; occupancy = 0/1/2 per state.
REQ-024 Latency: an entry accepted into EMPTY is visible on out_data/out_valid the next cycle; sustained throughput is 1 entry/cycle.
REQ-025 Ordering: entries leave strictly in acceptance order; no entry is duplicated or lost except by flush.
REQ-026 Payload registers update only on the transitions listed; held bits are stable while out_valid & ~out_ready.
REQ-027 flush has priority over accept and consume: next state EMPTY; any in-data accepted in the flush cycle is discarded.
REQ-028 flush with FLUSH_ZERO=1 zeroes main and skid; with FLUSH_ZERO=0 payload is held, valid cleared.
REQ-029 flush_cnt increments by 1 on a flush cycle with occupancy != 0; holds at 2^CNT_W-1; flush while EMPTY does not count.
REQ-030 Simultaneous flush and consume: the consume is still seen downstream that cycle; the entry is removed, not replayed.
REQ-031 in_data is ignored while in_ready = 0; in_valid may be withdrawn at any time with no effect.

Reset
REQ-032 While reset = 1, asynchronously: state EMPTY, out_valid 0, occupancy 0, main = skid = 0, flush_cnt 0.
REQ-033 After reset release, in_ready = 1 on the first edge, for both SKID settings.
REQ-034 Reset asserted mid-transfer (state TWO) drops both entries; no partial payload is ever presented.

Verification
REQ-035 Stream: in_valid=1 with data 1,2,3,4 on consecutive cycles, out_ready=1 -> out_data 1,2,3,4 one cycle later each, occupancy 1, in_ready stays 1.
REQ-036 Backpressure SKID=1: out_ready=0, send A then B -> occupancy 2, in_ready 0, out_data=A; raise out_ready -> A, then B, in_ready 1 after A leaves.
REQ-037 Backpressure SKID=0: out_ready=0 with A held -> in_ready 0 that cycle, B not accepted; out_ready=1 with B offered -> A consumed and B loaded on the same edge.
REQ-038 Flush at occupancy 2 with FLUSH_ZERO=1 and in_valid=1 carrying C -> next cycle out_valid 0, out_data 0, occupancy 0, C lost, flush_cnt 1; flush while EMPTY -> flush_cnt stays 1.
REQ-039 Saturation with CNT_W=2: 5 flushes at occupancy 1 -> flush_cnt 3.
REQ-040 Asynchronous reset pulse between clock edges while in TWO -> outputs cleared immediately, in_ready 1 after release, next accepted value D appears alone.
